// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions for the register slice: response codes, skid
// buffer state encoding and channel payload width helpers.
package axi_lite_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    localparam int RESP_WIDTH = 2;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_e;

    function automatic int w_payload_width(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int r_payload_width(input int data_w);
        return data_w + RESP_WIDTH;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle of all five channels. The master modport drives AW/W/AR and
// the B/R readies; the slave modport is the mirror image.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );

endinterface

// File: rtl/axi_lite_skid_buf.sv
// Generic two-entry valid/ready skid buffer. Every output comes straight from a
// register, so no input reaches an output combinationally.
module axi_lite_skid_buf
    import axi_lite_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             push;
    logic             pop;

    assign push        = in_valid_i & in_ready_q;
    assign pop         = out_valid_q & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

    // main_q only changes when empty or popped, which keeps the payload stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (push) begin
                        main_q      <= in_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= in_data_i;
                    end else if (push) begin
                        skid_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_reg_slice.sv
// Full-throughput AXI-Lite register slice: one skid buffer per channel.
// Define AXIL_SLICE_STATS_EN to add the wr_cnt/rd_cnt response counters.
module axi_lite_reg_slice
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    axi_lite_if.slave   up,
    axi_lite_if.master  dn
`ifdef AXIL_SLICE_STATS_EN
    ,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt
`endif
);

    localparam int W_WIDTH = w_payload_width(DATA_WIDTH);
    localparam int R_WIDTH = r_payload_width(DATA_WIDTH);

    logic [W_WIDTH-1:0] w_in;
    logic [W_WIDTH-1:0] w_out;
    logic [R_WIDTH-1:0] r_in;
    logic [R_WIDTH-1:0] r_out;

    assign w_in                  = {up.w_data, up.w_strb};
    assign {dn.w_data, dn.w_strb} = w_out;
    assign r_in                  = {dn.r_data, dn.r_resp};
    assign {up.r_data, up.r_resp} = r_out;

    axi_lite_skid_buf #(.WIDTH(ADDR_WIDTH)) u_aw (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (up.aw_valid),
        .in_ready_o  (up.aw_ready),
        .in_data_i   (up.aw_addr),
        .out_valid_o (dn.aw_valid),
        .out_ready_i (dn.aw_ready),
        .out_data_o  (dn.aw_addr)
    );

    axi_lite_skid_buf #(.WIDTH(W_WIDTH)) u_w (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (up.w_valid),
        .in_ready_o  (up.w_ready),
        .in_data_i   (w_in),
        .out_valid_o (dn.w_valid),
        .out_ready_i (dn.w_ready),
        .out_data_o  (w_out)
    );

    // Response channels run in the reverse direction, target towards bridge
    axi_lite_skid_buf #(.WIDTH(RESP_WIDTH)) u_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (dn.b_valid),
        .in_ready_o  (dn.b_ready),
        .in_data_i   (dn.b_resp),
        .out_valid_o (up.b_valid),
        .out_ready_i (up.b_ready),
        .out_data_o  (up.b_resp)
    );

    axi_lite_skid_buf #(.WIDTH(ADDR_WIDTH)) u_ar (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (up.ar_valid),
        .in_ready_o  (up.ar_ready),
        .in_data_i   (up.ar_addr),
        .out_valid_o (dn.ar_valid),
        .out_ready_i (dn.ar_ready),
        .out_data_o  (dn.ar_addr)
    );

    axi_lite_skid_buf #(.WIDTH(R_WIDTH)) u_r (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (dn.r_valid),
        .in_ready_o  (dn.r_ready),
        .in_data_i   (r_in),
        .out_valid_o (up.r_valid),
        .out_ready_i (up.r_ready),
        .out_data_o  (r_out)
    );

`ifdef AXIL_SLICE_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;

    // Counters wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (up.b_valid && up.b_ready) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (up.r_valid && up.r_ready) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule
